// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: FSM state encodings
// and counter sizing.
package div_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = $clog2(DIV_WIDTH) + 1;

    // Counter must hold the value WIDTH itself, hence the extra bit.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_signed_divider_udiv_step.sv
// One restoring-division iteration on unsigned magnitudes: shift {R,Q} left,
// subtract the divisor when it fits, and record the quotient bit.
module udiv_step
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;
    logic           fits;

    // Compare on WIDTH+1 bits: the shifted remainder can exceed 2^WIDTH-1.
    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        fits    = (shifted >= {1'b0, divisor});
        rem_out = fits ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
        quo_out = {quo_in[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Multicycle signed divider (DIV): magnitudes are divided one bit per clock,
// then a fix-up cycle applies the quotient/remainder signs.
module seq_signed_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sign_q_q, sign_q_d;
    logic             sign_r_q, sign_r_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_r, step_q;

    udiv_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (r_q),
        .quo_in  (q_q),
        .divisor (dvs_q),
        .rem_out (step_r),
        .quo_out (step_q)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        q_d         = q_q;
        dvs_d       = dvs_q;
        sign_q_d    = sign_q_q;
        sign_r_d    = sign_r_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (b == '0) begin
                        dbz_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        // Unsigned WIDTH-bit magnitude keeps |-2^(WIDTH-1)| exact.
                        q_d      = a[WIDTH-1] ? -a : a;
                        dvs_d    = b[WIDTH-1] ? -b : b;
                        r_d      = '0;
                        sign_q_d = a[WIDTH-1] ^ b[WIDTH-1];
                        sign_r_d = a[WIDTH-1];
                        cnt_d    = CW'(WIDTH);
                        dbz_d    = 1'b0;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                r_d   = step_r;
                q_d   = step_q;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
                quotient_d  = sign_q_q ? -q_q : q_q;
                remainder_d = sign_r_q ? -r_q : r_q;
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            dvs_q       <= '0;
            sign_q_q    <= 1'b0;
            sign_r_q    <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            q_q         <= q_d;
            dvs_q       <= dvs_d;
            sign_q_q    <= sign_q_d;
            sign_r_q    <= sign_r_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == RUN) || (state_q == FIX);

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider against a plain / and % model.
module tb_seq_signed_divider;

    localparam int W = 32;
    localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a, b;
    logic [W-1:0] quotient, remainder;
    logic         done, div_by_zero, busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_signed_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .a           (a),
        .b           (b),
        .start       (start),
        .quotient    (quotient),
        .remainder   (remainder),
        .done        (done),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    // Truncating signed division; remainder follows the dividend's sign.
    function automatic void ref_div(input logic [W-1:0] x, input logic [W-1:0] y,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        logic signed [W-1:0] sx, sy;
        sx = x;
        sy = y;
        if (x == MIN_NEG && y == '1) begin
            q = MIN_NEG;
            r = '0;
        end else begin
            q = sx / sy;
            r = sx % sy;
        end
    endfunction

    // Issues a one-cycle start, counts edges after the accepting edge until done,
    // then reports whether done was still high one cycle later.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output logic done_again);
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        @(posedge clk); @(negedge clk);
        done_again = done;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (quotient !== '0) begin bad++; $display("FAIL reset_quotient got=%h exp=0", quotient); end
        total++; if (remainder !== '0) begin bad++; $display("FAIL reset_remainder got=%h exp=0", remainder); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int lat, busy_cnt;
        @(negedge clk);
        a = 7; b = 2; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0; busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            @(posedge clk); lat++; @(negedge clk);
        end
        total++; if (lat != W + 1) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", lat, W + 1); end
        total++; if (busy_cnt != W + 1) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", busy_cnt, W + 1); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
        total++; if (quotient !== 32'd3) begin bad++; $display("FAIL basic_quotient got=%h exp=3", quotient); end
        total++; if (remainder !== 32'd1) begin bad++; $display("FAIL basic_remainder got=%h exp=1", remainder); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL basic_dbz got=%b exp=0", div_by_zero); end
        @(posedge clk); @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%b exp=0", done); end
    endtask

    task automatic test_signs;
        logic [W-1:0] xs [5] = '{32'hFFFF_FFF9, 32'd7,         32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9};
        logic [W-1:0] ys [5] = '{32'd2,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFE};
        logic [W-1:0] eq [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'd3};
        logic [W-1:0] er [5] = '{32'hFFFF_FFFF, 32'd1,         32'd0,         32'd0,         32'hFFFF_FFFF};
        int lat;
        logic again;
        for (int i = 0; i < 5; i++) begin
            run_op(xs[i], ys[i], lat, again);
            total++; if (quotient !== eq[i]) begin bad++; $display("FAIL signs_quotient[%0d] got=%h exp=%h", i, quotient, eq[i]); end
            total++; if (remainder !== er[i]) begin bad++; $display("FAIL signs_remainder[%0d] got=%h exp=%h", i, remainder, er[i]); end
            total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL signs_dbz[%0d] got=%b exp=0", i, div_by_zero); end
            total++; if (lat != W + 1) begin bad++; $display("FAIL signs_latency[%0d] got=%0d exp=%0d", i, lat, W + 1); end
        end
    endtask

    task automatic test_div_by_zero;
        int lat;
        logic again;
        run_op(32'd7, 32'd2, lat, again);
        @(negedge clk);
        a = 5; b = 0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL dbz_done got=%b exp=1", done); end
        total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag got=%b exp=1", div_by_zero); end
        total++; if (quotient !== 32'd3) begin bad++; $display("FAIL dbz_quotient_held got=%h exp=3", quotient); end
        total++; if (remainder !== 32'd1) begin bad++; $display("FAIL dbz_remainder_held got=%h exp=1", remainder); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL dbz_busy got=%b exp=0", busy); end
        @(posedge clk); @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL dbz_done_width got=%b exp=0", done); end
        total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag_hold got=%b exp=1", div_by_zero); end
        run_op(32'd20, 32'd6, lat, again);
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL dbz_clear got=%b exp=0", div_by_zero); end
        total++; if (quotient !== 32'd3 || remainder !== 32'd2) begin bad++; $display("FAIL dbz_next_result got=%h/%h exp=3/2", quotient, remainder); end
    endtask

    task automatic test_ignore_start;
        int lat;
        @(negedge clk);
        a = 100; b = 7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            if (lat == 5) begin a = 9; b = 3; start = 1'b1; end
            else start = 1'b0;
            @(posedge clk); lat++; @(negedge clk);
        end
        start = 1'b0;
        total++; if (lat != W + 1) begin bad++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, W + 1); end
        total++; if (quotient !== 32'd14) begin bad++; $display("FAIL ignore_quotient got=%h exp=e", quotient); end
        total++; if (remainder !== 32'd2) begin bad++; $display("FAIL ignore_remainder got=%h exp=2", remainder); end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset_abort;
        logic seen_done;
        @(negedge clk);
        a = 100; b = 7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) begin @(posedge clk); @(negedge clk); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        total++; if (quotient !== '0) begin bad++; $display("FAIL abort_quotient got=%h exp=0", quotient); end
        total++; if (remainder !== '0) begin bad++; $display("FAIL abort_remainder got=%h exp=0", remainder); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", done); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL abort_dbz got=%b exp=0", div_by_zero); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk); @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b exp=0", seen_done); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] x1, y1, x2, y2, q1, r1, q2, r2;
        int n1, n2;
        x1 = -32'sd100; y1 = 32'd9;
        x2 = 32'd50;    y2 = -32'sd8;
        ref_div(x1, y1, q1, r1);
        ref_div(x2, y2, q2, r2);
        @(negedge clk);
        a = x1; b = y1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = x2; b = y2;
        n1 = 0;
        while (!done && n1 < 100) begin
            @(posedge clk); n1++; @(negedge clk);
        end
        total++; if (n1 != W + 1) begin bad++; $display("FAIL b2b_latency1 got=%0d exp=%0d", n1, W + 1); end
        total++; if (quotient !== q1 || remainder !== r1) begin bad++; $display("FAIL b2b_result1 got=%h/%h exp=%h/%h", quotient, remainder, q1, r1); end
        n2 = 0;
        do begin
            @(posedge clk); n2++; @(negedge clk);
            start = 1'b0;
        end while (!done && n2 < 100);
        total++; if (n2 != W + 2) begin bad++; $display("FAIL b2b_latency2 got=%0d exp=%0d", n2, W + 2); end
        total++; if (quotient !== q2 || remainder !== r2) begin bad++; $display("FAIL b2b_result2 got=%h/%h exp=%h/%h", quotient, remainder, q2, r2); end
        @(posedge clk); @(negedge clk);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return MIN_NEG;
            1:       return '1;
            2:       return 32'd1;
            3:       return 32'h7FFF_FFFF;
            4:       return W'($urandom_range(0, 15)) - 32'd8;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic test_random;
        logic [W-1:0] x, y, eq, er;
        int lat;
        logic again;
        for (int i = 0; i < 1000; i++) begin
            x = pick_operand();
            y = pick_operand();
            if (y == '0) y = 32'd1;
            ref_div(x, y, eq, er);
            run_op(x, y, lat, again);
            total++; if (quotient !== eq) begin bad++; $display("FAIL rand_quotient a=%h b=%h got=%h exp=%h", x, y, quotient, eq); end
            total++; if (remainder !== er) begin bad++; $display("FAIL rand_remainder a=%h b=%h got=%h exp=%h", x, y, remainder, er); end
            total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL rand_dbz a=%h b=%h got=%b exp=0", x, y, div_by_zero); end
            total++; if (lat != W + 1) begin bad++; $display("FAIL rand_latency a=%h b=%h got=%0d exp=%0d", x, y, lat, W + 1); end
            total++; if (again !== 1'b0) begin bad++; $display("FAIL rand_done_width a=%h b=%h got=%b exp=0", x, y, again); end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0;
        test_reset();
        test_basic();
        test_signs();
        test_div_by_zero();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
